// File: rtl/exec_domain_pkg.sv
// Shared types and constants for the exec_domain execution block.
//   op_e    : instruction opcodes carried in byte0 of each instruction
//   state_e : decode/execute FSM states
package exec_domain_pkg;

    typedef enum logic [7:0] {
        OP_NOP = 8'h00,
        OP_LDI = 8'h01,
        OP_MOV = 8'h02,
        OP_ADD = 8'h03,
        OP_SUB = 8'h04,
        OP_AND = 8'h05,
        OP_OR  = 8'h06,
        OP_XOR = 8'h07,
        OP_OUT = 8'h08
    } op_e;

    typedef enum logic [2:0] {
        S_OP,
        S_RD,
        S_RS,
        S_IMM,
        S_EXEC,
        S_OUT
    } state_e;

    localparam int         IMM_BYTES_MAX  = 8;
    localparam logic [7:0] OP_ILLEGAL_MIN = 8'h09;

endpackage

// File: rtl/exec_alu.sv
// Combinational ALU for exec_domain.
//   op     : opcode selecting the operation
//   a, b   : operands (a = rd value, b = rs value)
//   result : operation result (MOV passes b through)
//   carry  : carry-out for ADD, borrow for SUB, 0 otherwise
//   zero   : result == 0
module exec_alu
    import exec_domain_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  op_e             op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic [XLEN-1:0] result,
    output logic            carry,
    output logic            zero
);

    logic [XLEN:0] ext;

    always_comb begin
        ext    = '0;
        result = '0;
        carry  = 1'b0;
        case (op)
            OP_ADD: begin
                ext    = {1'b0, a} + {1'b0, b};
                result = ext[XLEN-1:0];
                carry  = ext[XLEN];
            end
            OP_SUB: begin
                // The extra bit wraps to 1 exactly when a < b (unsigned).
                ext    = {1'b0, a} - {1'b0, b};
                result = ext[XLEN-1:0];
                carry  = ext[XLEN];
            end
            OP_AND:  result = a & b;
            OP_OR:   result = a | b;
            OP_XOR:  result = a ^ b;
            OP_MOV:  result = b;
            default: result = '0;
        endcase
    end

    assign zero = (result == '0);

endmodule

// File: rtl/exec_domain.sv
// Parametrised execution domain: decodes an 8-bit instruction byte stream,
// executes on an internal register file and ALU, and emits OUT results.
//   clk, reset           : clock, synchronous active-high reset
//   bus_in/valid/ready   : instruction byte input with valid/ready handshake
//   out_data/valid/ready : OUT result port with valid/ready handshake
//   flag_z, flag_c       : zero / carry(borrow) of the last flag-setting op
//   err                  : sticky error (illegal opcode or register index)
//   busy                 : FSM is mid-instruction (not in S_OP)
module exec_domain
    import exec_domain_pkg::*;
#(
    parameter int XLEN  = 64,
    parameter int NREGS = 64
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [7:0]      bus_in,
    input  logic            bus_valid,
    output logic            bus_ready,
    output logic [XLEN-1:0] out_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic            flag_z,
    output logic            flag_c,
    output logic            err,
    output logic            busy
);

    localparam int         RSEL_W   = $clog2(NREGS);
    localparam logic [6:0] NREGS_L  = 7'(NREGS);
    localparam logic [2:0] CNT_LAST = 3'(XLEN / 8 - 1);

    state_e          state_q;
    op_e             op_q;
    logic [5:0]      rd_q;
    logic [5:0]      rs_q;
    logic [XLEN-1:0] imm_q;
    logic [2:0]      cnt_q;
    logic [XLEN-1:0] out_data_q;
    logic            out_valid_q;
    logic            flag_z_q;
    logic            flag_c_q;
    logic            err_q;
    logic [XLEN-1:0] regs_q [NREGS];

    logic              accept;
    logic              rd_ok;
    logic              rs_ok;
    logic              bus_idx_ok;
    logic [RSEL_W-1:0] rd_idx;
    logic [RSEL_W-1:0] rs_idx;
    logic [XLEN-1:0]   alu_result;
    logic              alu_carry;
    logic              alu_zero;
    logic              wb_en_d;
    logic [XLEN-1:0]   wb_data_d;
    logic              exec_err_d;

    assign bus_ready = (state_q == S_OP) || (state_q == S_RD) ||
                       (state_q == S_RS) || (state_q == S_IMM);
    assign busy      = (state_q != S_OP);
    assign accept    = bus_valid && bus_ready;

    // Index fields are 6 bits wide; anything at or above NREGS is invalid.
    assign rd_ok      = ({1'b0, rd_q} < NREGS_L);
    assign rs_ok      = ({1'b0, rs_q} < NREGS_L);
    assign bus_idx_ok = ({1'b0, bus_in[5:0]} < NREGS_L);
    assign rd_idx     = rd_q[RSEL_W-1:0];
    assign rs_idx     = rs_q[RSEL_W-1:0];

    exec_alu #(.XLEN(XLEN)) u_alu (
        .op     (op_q),
        .a      (regs_q[rd_idx]),
        .b      (regs_q[rs_idx]),
        .result (alu_result),
        .carry  (alu_carry),
        .zero   (alu_zero)
    );

    // Writeback decision for the single S_EXEC cycle.
    always_comb begin
        wb_en_d    = 1'b0;
        wb_data_d  = alu_result;
        exec_err_d = 1'b0;
        if (state_q == S_EXEC) begin
            if (op_q == OP_LDI) begin
                wb_en_d    = rd_ok;
                wb_data_d  = imm_q;
                exec_err_d = !rd_ok;
            end else begin
                wb_en_d    = rd_ok && rs_ok;
                exec_err_d = !(rd_ok && rs_ok);
            end
        end
    end

    for (genvar gi = 0; gi < NREGS; gi++) begin : g_regs
        always_ff @(posedge clk) begin
            if (reset) begin
                regs_q[gi] <= '0;
            end else if (wb_en_d && (rd_idx == RSEL_W'(gi))) begin
                regs_q[gi] <= wb_data_d;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_OP;
            op_q        <= OP_NOP;
            rd_q        <= '0;
            rs_q        <= '0;
            imm_q       <= '0;
            cnt_q       <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            flag_z_q    <= 1'b0;
            flag_c_q    <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            case (state_q)
                S_OP: begin
                    if (accept) begin
                        op_q <= op_e'(bus_in);
                        if (bus_in == OP_NOP) begin
                            state_q <= S_OP;
                        end else if (bus_in == OP_OUT) begin
                            state_q <= S_RS;
                        end else if (bus_in < OP_ILLEGAL_MIN) begin
                            state_q <= S_RD;
                        end else begin
                            // Illegal opcode: flag it and resync on the next byte.
                            err_q <= 1'b1;
                        end
                    end
                end
                S_RD: begin
                    if (accept) begin
                        rd_q <= bus_in[5:0];
                        if (op_q == OP_LDI) begin
                            cnt_q   <= '0;
                            state_q <= S_IMM;
                        end else begin
                            state_q <= S_RS;
                        end
                    end
                end
                S_RS: begin
                    if (accept) begin
                        rs_q <= bus_in[5:0];
                        if (op_q == OP_OUT) begin
                            if (bus_idx_ok) begin
                                out_data_q  <= regs_q[bus_in[RSEL_W-1:0]];
                                out_valid_q <= 1'b1;
                                state_q     <= S_OUT;
                            end else begin
                                err_q   <= 1'b1;
                                state_q <= S_OP;
                            end
                        end else begin
                            state_q <= S_EXEC;
                        end
                    end
                end
                S_IMM: begin
                    if (accept) begin
                        // Little-endian: byte n lands in bits [8n+7:8n].
                        imm_q[{cnt_q, 3'b000} +: 8] <= bus_in;
                        if (cnt_q == CNT_LAST) begin
                            state_q <= S_EXEC;
                        end else begin
                            cnt_q <= cnt_q + 3'd1;
                        end
                    end
                end
                S_EXEC: begin
                    if (exec_err_d) begin
                        err_q <= 1'b1;
                    end else begin
                        case (op_q)
                            OP_ADD, OP_SUB: begin
                                flag_z_q <= alu_zero;
                                flag_c_q <= alu_carry;
                            end
                            OP_AND, OP_OR, OP_XOR: flag_z_q <= alu_zero;
                            default: ;
                        endcase
                    end
                    state_q <= S_OP;
                end
                S_OUT: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= S_OP;
                    end
                end
                default: state_q <= S_OP;
            endcase
        end
    end

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign flag_z    = flag_z_q;
    assign flag_c    = flag_c_q;
    assign err       = err_q;

endmodule
